spi_eeprom_slave: RTL and testbench
===================================

# spi_eeprom_slave

Synthesizable SPI responder that emulates a 128 x 8 serial EEPROM (25AA010A-style command set) on the far end of the team's Wishbone-to-SPI master. It oversamples the SPI pins with the system clock, decodes opcodes, and serves reads, page writes and status accesses. A timed write cycle with a WIP status bit is included. It replaces the behavioural memory model so that the full SPI path can be synthesized and run on hardware.

## Interface
- `PAGE_BYTES`, 16: page size; write address wraps inside the page.
- `TWC_CYCLES`, 5000: internal write-cycle duration in CLK_I cycles.
- `CLK_I` in 1: system clock, must be ≥ 8× SPI_CLK frequency.
- `RST_N_I` in 1: reset; one clock; reset is asynchronous and active-low.
- `SPI_CLK` in 1: serial clock, mode 0 (idle low).
- `SPI_CS_N` in 1: chip select, active low.
- `SPI_MOSI` in 1: serial data in, MSB first.
- `SPI_MISO` out 1: serial data out, MSB first.
- `SPI_MISO_OE` out 1: output enable for the MISO pad driver.
- `BUSY_O` out 1: mirror of status WIP.

## Operation
- SPI_CLK, SPI_CS_N and SPI_MOSI each pass through a 2-flop synchronizer followed by an edge-detect register. MOSI is shifted on a detected SCK rise. MISO is updated on a detected SCK fall.
- A detected CS_N rise, or CS_N high, aborts the transaction: FSM→IDLE, bit counter cleared, SPI_MISO_OE=0.
- FSM states:
  - IDLE
  - CMD: 8 bits.
  - ADDR: 8 bits; MSB ignored, 7-bit address.
  - RDATA
  - WDATA
  - SRREAD
  - SRWRITE
  - IGNORE: unknown opcode; stays here until CS_N rises.
- Opcodes:
  - READ 0x03: ADDR then RDATA. Data streams from the address, auto-incrementing; wraps 0x7F→0x00.
  - WRITE 0x02: accepted only if WEL=1 and WIP=0, otherwise →IGNORE. ADDR then WDATA. Each complete byte is buffered in the page latch; the address wraps within `PAGE_BYTES`, so later bytes overwrite earlier ones. Partial trailing bytes are discarded.
  - WREN 0x06 sets WEL. WRDI 0x04 clears WEL. Both take effect only on the 8th bit.
  - RDSR 0x05: status byte repeats until CS_N rises.
  - WRSR 0x01: needs WEL=1; writes BP bits at CS_N rise.
- Status: bit0 WIP, bit1 WEL, bits3:2 BP1:BP0, other bits 0.
- Write cycle: a CS_N rise after ≥1 full data byte commits the buffered bytes to the array, sets WIP=1 for `TWC_CYCLES` clocks, then clears WIP and WEL. A CS_N rise with zero data bytes commits nothing and leaves WEL set.
- While WIP=1, only RDSR is honored; all other opcodes →IGNORE.
- Reset: FSM IDLE, status 0x00, write timer 0, SPI_MISO=0, SPI_MISO_OE=0, BUSY_O=0. The memory array is not reset. A reset during a write cycle aborts it; any array bytes not yet committed are lost.

## Timing
- Input-to-edge latency: 3 CLK_I cycles from a pin change to the detected edge.
- SPI_MISO changes 3–4 CLK_I after an SCK fall and is stable well before the next rise when SCK half-period ≥ 4 CLK_I.
- First MISO bit of RDATA/SRREAD is driven after the SCK fall that follows the last ADDR or CMD bit.
- SPI_MISO_OE rises together with that first bit and falls 3 CLK_I after a CS_N rise.
- Commit: the array is written one byte per CLK_I, starting the cycle after CS_N rise detection. WIP rises in that same cycle and falls exactly `TWC_CYCLES` later.

## Configuration
- `SPI_EEPROM_BP_EN` defined: the BP bits are writable through WRSR. Writes are blocked as follows:
  - BP=01: addresses 0x60–0x7F.
  - BP=10: 0x40–0x7F.
  - BP=11: all addresses.
  - A blocked WRITE is accepted on the bus but commits nothing and sets no WIP; WEL is still cleared at CS_N rise.
- Undefined: BP bits read 0, WRSR is decoded but has no effect, and no protection is applied.

## Structure
- `spi_eeprom_pkg` holds:
  - opcode constants
  - status bit indices
  - the FSM state enum
  - `ADDR_W`=7
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall detect, instantiated once per input pin.
- Memory is a 128x8 register array with a synchronous write port.

## Test plan
- WREN, WRITE 0x02 addr 0x10 data 0xA5 0x3C, CS_N high → WIP=1 for 5000 cycles. Then READ 0x03 addr 0x10 returns 0xA5, 0x3C.
- WRITE with WEL=0 → no commit; RDSR returns 0x00 and the array is unchanged.
- WREN, WRITE addr 0x1E with 4 bytes 0x01..0x04 → 0x1E=0x01, 0x1F=0x02, 0x10=0x03, 0x11=0x04 (page wrap).
- READ at 0x7F for 2 bytes → array[0x7F], then array[0x00].
- RDSR polled during the write cycle returns 0x03, then 0x00 after completion. A READ issued during WIP leaves MISO_OE=0.
- `SPI_EEPROM_BP_EN` defined: WREN, WRSR 0x0C, WREN, WRITE to 0x05 → no WIP, data unchanged. With the macro undefined, the same sequence commits.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// Shared constants, status bit layout and FSM states for the SPI EEPROM responder.
// Also holds the block-protect address check used when SPI_EEPROM_BP_EN is defined.
package spi_eeprom_pkg;

  localparam int ADDR_W    = 7;
  localparam int MEM_DEPTH = 128;

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;
  localparam int SR_BP0 = 2;
  localparam int SR_BP1 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_SRREAD,
    ST_SRWRITE,
    ST_IGNORE
  } state_e;

  // Regions are page aligned, so checking the page base covers every byte of the page.
  function automatic logic bp_blocked(input logic [1:0] bp, input logic [ADDR_W-1:0] addr);
    logic blk;
    case (bp)
      2'b01:   blk = (addr[6:5] == 2'b11);
      2'b10:   blk = addr[6];
      2'b11:   blk = 1'b1;
      default: blk = 1'b0;
    endcase
    return blk;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one SPI pin followed by an edge-detect register.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      dly_r  <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~dly_r;
  assign fall  = ~sync_r & dly_r;

endmodule

// File: rtl/spi_eeprom_slave.sv
// 128x8 SPI EEPROM responder (mode 0) with page buffer and timed write cycle.
// Define SPI_EEPROM_BP_EN to make the BP status bits writable and enforce write protection.
module spi_eeprom_slave
  import spi_eeprom_pkg::*;
#(
  parameter int PAGE_BYTES = 16,
  parameter int TWC_CYCLES = 5000
) (
  input  logic CLK_I,
  input  logic RST_N_I,
  input  logic SPI_CLK,
  input  logic SPI_CS_N,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic SPI_MISO_OE,
  output logic BUSY_O
);

  localparam int PG_W  = $clog2(PAGE_BYTES);
  localparam int TMR_W = $clog2(TWC_CYCLES);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ~ADDR_W'(PAGE_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TWC_CYCLES - 1);
  localparam logic [PG_W-1:0]   IDX_LAST  = PG_W'(PAGE_BYTES - 1);

  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic cs_hi_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic [3:0] sync_unused_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(CLK_I), .rst_n(RST_N_I), .din(SPI_CLK),
    .level(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(CLK_I), .rst_n(RST_N_I), .din(SPI_CS_N),
    .level(cs_hi_s), .rise(cs_rise_s), .fall(cs_fall_s));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(CLK_I), .rst_n(RST_N_I), .din(SPI_MOSI),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

  assign sync_unused_s = {sck_lvl_s, cs_fall_s, mosi_rise_s, mosi_fall_s};

  state_e state_r, state_nx_s, cmd_next_s;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r, byte_s, tx_r, status_s;
  logic              miso_r, oe_r, wel_r, wip_r, cmd_read_r, wr_any_r;
  logic [ADDR_W-1:0] addr_r, page_base_r, cmt_wa_s;
  logic [PG_W-1:0]   page_off_r, cmt_idx_r;
  logic              cmt_act_r;
  logic [TMR_W-1:0]  timer_r;
  logic [PAGE_BYTES-1:0] page_vld_r;
  logic [7:0]        page_data_r [PAGE_BYTES];
  logic [7:0]        mem_r [MEM_DEPTH];
  logic [1:0]        bp_s;
  logic              blocked_s;
  logic byte_done_s, cmd_done_s, addr_done_s, rdata_done_s, srread_done_s;
  logic data_byte_s, wr_accept_s, end_wdata_s, commit_start_s;

  assign byte_s        = {shift_r[6:0], mosi_s};
  assign byte_done_s   = sck_rise_s & ~cs_hi_s & (bit_cnt_r == 3'd7);
  assign cmd_done_s    = byte_done_s & (state_r == ST_CMD);
  assign addr_done_s   = byte_done_s & (state_r == ST_ADDR);
  assign rdata_done_s  = byte_done_s & (state_r == ST_RDATA);
  assign srread_done_s = byte_done_s & (state_r == ST_SRREAD);
  assign data_byte_s   = byte_done_s & (state_r == ST_WDATA);
  assign wr_accept_s   = cmd_done_s & (byte_s == OP_WRITE) & wel_r & ~wip_r;
  assign end_wdata_s   = cs_rise_s & (state_r == ST_WDATA) & wr_any_r;
  assign commit_start_s = end_wdata_s & ~blocked_s;
  assign status_s      = {4'b0000, bp_s, wel_r, wip_r};
  assign cmt_wa_s      = page_base_r | ADDR_W'(cmt_idx_r);

`ifdef SPI_EEPROM_BP_EN
  logic [1:0] bp_r, sr_bp_r;
  logic       sr_full_r;

  // BP bits only change at CS_N rise after a complete WRSR data byte
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      bp_r      <= 2'b00;
      sr_bp_r   <= 2'b00;
      sr_full_r <= 1'b0;
    end else if ((state_r == ST_SRWRITE) && byte_done_s) begin
      sr_bp_r   <= byte_s[SR_BP1:SR_BP0];
      sr_full_r <= 1'b1;
    end else if ((state_r == ST_SRWRITE) && cs_rise_s && sr_full_r) begin
      bp_r      <= sr_bp_r;
      sr_full_r <= 1'b0;
    end else if (cs_hi_s) begin
      sr_full_r <= 1'b0;
    end
  end

  assign bp_s      = bp_r;
  assign blocked_s = bp_blocked(bp_r, page_base_r);
`else
  assign bp_s      = 2'b00;
  assign blocked_s = 1'b0;
`endif

  // Opcode decode; everything except RDSR is refused while a write cycle runs
  always_comb begin
    cmd_next_s = ST_IGNORE;
    case (byte_s)
      OP_READ:  if (wip_r) cmd_next_s = ST_IGNORE; else cmd_next_s = ST_ADDR;
      OP_WRITE: if (wel_r && !wip_r) cmd_next_s = ST_ADDR; else cmd_next_s = ST_IGNORE;
      OP_RDSR:  cmd_next_s = ST_SRREAD;
      OP_WRSR:  if (wel_r && !wip_r) cmd_next_s = ST_SRWRITE; else cmd_next_s = ST_IGNORE;
      default:  cmd_next_s = ST_IGNORE;
    endcase
  end

  // Next-state logic; CS_N high always returns to IDLE
  always_comb begin
    state_nx_s = state_r;
    if (cs_hi_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nx_s = ST_CMD;
        ST_CMD:  if (byte_done_s) state_nx_s = cmd_next_s; else state_nx_s = ST_CMD;
        ST_ADDR: begin
          if (byte_done_s) begin
            if (cmd_read_r) state_nx_s = ST_RDATA; else state_nx_s = ST_WDATA;
          end else begin
            state_nx_s = ST_ADDR;
          end
        end
        default: state_nx_s = state_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state_r <= ST_IDLE;
    else          state_r <= state_nx_s;
  end

  // Shifters, addresses, status bits, write-cycle timer and commit sequencer
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      tx_r        <= 8'h00;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      wel_r       <= 1'b0;
      wip_r       <= 1'b0;
      timer_r     <= '0;
      cmd_read_r  <= 1'b0;
      wr_any_r    <= 1'b0;
      addr_r      <= '0;
      page_base_r <= '0;
      page_off_r  <= '0;
      cmt_act_r   <= 1'b0;
      cmt_idx_r   <= '0;
    end else begin
      if (cs_hi_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sck_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= byte_s;
      end

      if (cmd_done_s) cmd_read_r <= (byte_s == OP_READ);

      if (addr_done_s) begin
        page_base_r <= byte_s[ADDR_W-1:0] & PAGE_MASK;
        page_off_r  <= byte_s[PG_W-1:0];
        addr_r      <= byte_s[ADDR_W-1:0] + 7'd1;
      end else if (rdata_done_s) begin
        addr_r <= addr_r + 7'd1;
      end else if (data_byte_s) begin
        page_off_r <= page_off_r + PG_W'(1);
      end

      // Next byte is loaded on the 8th rise so it is ready for the following fall
      if (cs_hi_s) begin
        miso_r <= 1'b0;
        oe_r   <= 1'b0;
      end else if (cmd_done_s && (byte_s == OP_RDSR)) begin
        tx_r <= status_s;
      end else if (addr_done_s) begin
        tx_r <= mem_r[byte_s[ADDR_W-1:0]];
      end else if (rdata_done_s) begin
        tx_r <= mem_r[addr_r];
      end else if (srread_done_s) begin
        tx_r <= status_s;
      end else if (sck_fall_s && ((state_r == ST_RDATA) || (state_r == ST_SRREAD))) begin
        miso_r <= tx_r[7];
        tx_r   <= {tx_r[6:0], 1'b0};
        oe_r   <= 1'b1;
      end

      if (wr_accept_s)      wr_any_r <= 1'b0;
      else if (data_byte_s) wr_any_r <= 1'b1;

      if (commit_start_s) begin
        wip_r   <= 1'b1;
        timer_r <= '0;
      end else if (wip_r) begin
        if (timer_r == TMR_LAST) begin
          wip_r <= 1'b0;
          wel_r <= 1'b0;
        end else begin
          timer_r <= timer_r + TMR_W'(1);
        end
      end else if (end_wdata_s) begin
        wel_r <= 1'b0;
      end else if (cmd_done_s && (byte_s == OP_WREN)) begin
        wel_r <= 1'b1;
      end else if (cmd_done_s && (byte_s == OP_WRDI)) begin
        wel_r <= 1'b0;
      end

      if (commit_start_s) begin
        cmt_act_r <= 1'b1;
        cmt_idx_r <= '0;
      end else if (cmt_act_r) begin
        if (cmt_idx_r == IDX_LAST) cmt_act_r <= 1'b0;
        cmt_idx_r <= cmt_idx_r + PG_W'(1);
      end
    end
  end

  // Page latch valid flags; a new accepted WRITE starts with an empty page
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)         page_vld_r <= '0;
    else if (wr_accept_s) page_vld_r <= '0;
    else if (data_byte_s) page_vld_r[page_off_r] <= 1'b1;
  end

  // Page latch data
  always_ff @(posedge CLK_I) begin
    if (data_byte_s) page_data_r[page_off_r] <= byte_s;
  end

  // Memory array: one buffered byte per clock during commit, never reset
  always_ff @(posedge CLK_I) begin
    if (cmt_act_r && page_vld_r[cmt_idx_r]) mem_r[cmt_wa_s] <= page_data_r[cmt_idx_r];
  end

  assign SPI_MISO    = miso_r;
  assign SPI_MISO_OE = oe_r;
  assign BUSY_O      = wip_r;

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed bench for spi_eeprom_slave: bit-banged SPI master with hand-computed expectations.
module tb_spi_eeprom_slave;

  localparam int HALF = 8;
  localparam int TWC  = 5000;

  logic CLK_I = 1'b0;
  logic RST_N_I = 1'b0;
  logic SPI_CLK = 1'b0;
  logic SPI_CS_N = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic SPI_MISO, SPI_MISO_OE, BUSY_O;

  int n_checks = 0;
  int n_fail = 0;
  int busy_len = 0;
  logic busy_prev = 1'b0;
  logic [7:0] sr, b0, b1, junk;
  logic oe;

  always #5 CLK_I = ~CLK_I;

  spi_eeprom_slave #(.PAGE_BYTES(16), .TWC_CYCLES(TWC)) dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I), .SPI_CLK(SPI_CLK), .SPI_CS_N(SPI_CS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .BUSY_O(BUSY_O));

  // Length of the most recent BUSY_O high run, in clocks
  always @(negedge CLK_I) begin
    if (BUSY_O === 1'b1) begin
      if (!busy_prev) busy_len = 1;
      else            busy_len = busy_len + 1;
    end
    busy_prev = BUSY_O;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_MOSI = tx[i];
      tick(HALF);
      rx[i] = SPI_MISO;
      SPI_CLK = 1'b1;
      tick(HALF);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic cs_on();
    SPI_CS_N = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_off();
    tick(HALF);
    SPI_CS_N = 1'b1;
    tick(12);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] r;
    cs_on(); spi_byte(op, r); cs_off();
  endtask

  task automatic rdsr(output logic [7:0] s);
    logic [7:0] r;
    cs_on(); spi_byte(8'h05, r); spi_byte(8'h00, s); cs_off();
  endtask

  task automatic wrsr(input logic [7:0] v);
    logic [7:0] r;
    cs_on(); spi_byte(8'h01, r); spi_byte(v, r); cs_off();
  endtask

  task automatic read2(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1,
                       output logic oe_seen);
    logic [7:0] r;
    cs_on(); spi_byte(8'h03, r); spi_byte(a, r);
    spi_byte(8'h00, d0);
    oe_seen = SPI_MISO_OE;
    spi_byte(8'h00, d1);
    cs_off();
  endtask

  // Bytes are taken from the top of data, n of them
  task automatic write_n(input logic [7:0] a, input logic [47:0] data, input int n);
    logic [7:0] r;
    cs_on(); spi_byte(8'h02, r); spi_byte(a, r);
    for (int i = 0; i < n; i++) spi_byte(data[47-8*i -: 8], r);
    cs_off();
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (BUSY_O && c < 6000) begin
      tick(1);
      c++;
    end
    check({tag, "_idle"}, {31'd0, BUSY_O}, 32'd0);
  endtask

  initial begin
    tick(3);
    RST_N_I = 1'b1;
    tick(3);
    check("rst_miso", {31'd0, SPI_MISO}, 32'd0);
    check("rst_oe", {31'd0, SPI_MISO_OE}, 32'd0);
    check("rst_busy", {31'd0, BUSY_O}, 32'd0);
    rdsr(sr);  check("sr_reset", {24'd0, sr}, 32'h00);

    cmd1(8'h06);
    rdsr(sr);  check("sr_wel", {24'd0, sr}, 32'h02);
    write_n(8'h10, {8'hA5, 8'h3C, 32'd0}, 2);
    check("busy_on", {31'd0, BUSY_O}, 32'd1);
    rdsr(sr);  check("sr_wip", {24'd0, sr}, 32'h03);
    cs_on(); spi_byte(8'h03, junk); spi_byte(8'h10, junk); spi_byte(8'h00, junk);
    check("oe_during_wip", {31'd0, SPI_MISO_OE}, 32'd0);
    cs_off();
    wait_idle("w1");
    check("twc_len", busy_len, TWC);
    rdsr(sr);  check("sr_after_wc", {24'd0, sr}, 32'h00);
    read2(8'h10, b0, b1, oe);
    check("rd10_b0", {24'd0, b0}, 32'hA5);
    check("rd10_b1", {24'd0, b1}, 32'h3C);
    check("rd_oe", {31'd0, oe}, 32'd1);

    write_n(8'h10, {8'h55, 40'd0}, 1);
    check("nowel_busy", {31'd0, BUSY_O}, 32'd0);
    rdsr(sr);  check("nowel_sr", {24'd0, sr}, 32'h00);
    read2(8'h10, b0, b1, oe);
    check("nowel_b0", {24'd0, b0}, 32'hA5);

    cmd1(8'h06);
    write_n(8'h1E, {8'h01, 8'h02, 8'h03, 8'h04, 16'd0}, 4);
    wait_idle("w2");
    read2(8'h1E, b0, b1, oe);
    check("wrap_1e", {24'd0, b0}, 32'h01);
    check("wrap_1f", {24'd0, b1}, 32'h02);
    read2(8'h10, b0, b1, oe);
    check("wrap_10", {24'd0, b0}, 32'h03);
    check("wrap_11", {24'd0, b1}, 32'h04);

    cmd1(8'h06);
    write_n(8'h7F, {8'h77, 40'd0}, 1);
    wait_idle("w3");
    cmd1(8'h06);
    write_n(8'h00, {8'h88, 8'h11, 8'h22, 8'h33, 8'h44, 8'h50}, 6);
    wait_idle("w4");
    read2(8'h7F, b0, b1, oe);
    check("rd7f", {24'd0, b0}, 32'h77);
    check("rd_wrap00", {24'd0, b1}, 32'h88);
    read2(8'h04, b0, b1, oe);
    check("rd04", {24'd0, b0}, 32'h44);
    check("rd05", {24'd0, b1}, 32'h50);

    cmd1(8'h06);
    write_n(8'h20, 48'd0, 0);
    check("zero_busy", {31'd0, BUSY_O}, 32'd0);
    rdsr(sr);  check("zero_sr", {24'd0, sr}, 32'h02);
    cmd1(8'h04);
    rdsr(sr);  check("wrdi_sr", {24'd0, sr}, 32'h00);

    cmd1(8'h06);
    wrsr(8'h0C);
    cmd1(8'h06);
    write_n(8'h05, {8'h99, 40'd0}, 1);
`ifdef SPI_EEPROM_BP_EN
    check("bp_busy", {31'd0, BUSY_O}, 32'd0);
    rdsr(sr);  check("bp_sr", {24'd0, sr}, 32'h0C);
    read2(8'h04, b0, b1, oe);
    check("bp_05", {24'd0, b1}, 32'h50);
`else
    check("nobp_busy", {31'd0, BUSY_O}, 32'd1);
    wait_idle("w5");
    rdsr(sr);  check("nobp_sr", {24'd0, sr}, 32'h00);
    read2(8'h04, b0, b1, oe);
    check("nobp_05", {24'd0, b1}, 32'h99);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
